// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) constants, column type, xtime helper and
// the iterative MixColumns FSM state encoding.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int         NB       = 4;
  localparam int         BYTE_W   = 8;

  typedef logic [NB*BYTE_W-1:0] col_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational (Inv)MixColumns on one 32-bit column; byte 0 sits in the MSBs.
module mix_column_unit
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [BYTE_W-1:0] a   [NB];
  logic [BYTE_W-1:0] x1  [NB];
  logic [BYTE_W-1:0] x2  [NB];
  logic [BYTE_W-1:0] x3  [NB];
  logic [BYTE_W-1:0] fwd [NB];
  logic [BYTE_W-1:0] rev [NB];

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      a[i]  = col_in[31-BYTE_W*i -: BYTE_W];
      x1[i] = xtime(a[i]);
      x2[i] = xtime(x1[i]);
      x3[i] = xtime(x2[i]);
    end
    col_out = '0;
    // Row i multiplies byte (i+k)%4 by matrix entry k of the first row.
    for (int i = 0; i < NB; i++) begin
      fwd[i] = x1[i]
             ^ (x1[(i+1)%NB] ^ a[(i+1)%NB])
             ^ a[(i+2)%NB]
             ^ a[(i+3)%NB];
      rev[i] = (x3[i] ^ x2[i] ^ x1[i])
             ^ (x3[(i+1)%NB] ^ x1[(i+1)%NB] ^ a[(i+1)%NB])
             ^ (x3[(i+2)%NB] ^ x2[(i+2)%NB] ^ a[(i+2)%NB])
             ^ (x3[(i+3)%NB] ^ a[(i+3)%NB]);
      col_out[31-BYTE_W*i -: BYTE_W] = inv ? rev[i] : fwd[i];
    end
  end

endmodule

// File: rtl/aes_mix_columns_iter.sv
// Iterative AES (Inv)MixColumns engine: COLS_PER_CYCLE columns per cycle,
// valid/ready on both sides, mode latched per block.
module aes_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int DATA_W         = 128,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic              inv_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [DATA_W-1:0] data_out
);

  localparam int         NUM_STEPS = NB / COLS_PER_CYCLE;
  localparam int         SHIFT     = $clog2(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_STEP = 2'(NUM_STEPS - 1);

  if (DATA_W != 128) begin : g_bad_data_w
    $error("aes_mix_columns_iter: DATA_W must be 128");
  end
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("aes_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t            state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic [DATA_W-1:0] data_q, data_d, data_xf;
  logic              inv_q, inv_d;
  logic              valid_q, valid_d;
  logic              rdy;

  col_t       cols      [NB];
  col_t       cols_next [NB];
  col_t       grp_in    [COLS_PER_CYCLE];
  col_t       grp_out   [COLS_PER_CYCLE];
  logic [1:0] grp_idx   [COLS_PER_CYCLE];

  // Column group for this step starts at step*C; C is a power of two.
  always_comb begin
    for (int c = 0; c < NB; c++) cols[c] = data_q[DATA_W-1-32*c -: 32];
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      grp_idx[g] = (step_q << SHIFT) | 2'(g);
      grp_in[g]  = cols[grp_idx[g]];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mcu
    mix_column_unit u_mcu (
      .col_in  (grp_in[g]),
      .inv     (inv_q),
      .col_out (grp_out[g])
    );
  end

  always_comb begin
    for (int c = 0; c < NB; c++) begin
      cols_next[c] = cols[c];
      for (int g = 0; g < COLS_PER_CYCLE; g++)
        if (grp_idx[g] == 2'(c)) cols_next[c] = grp_out[g];
    end
    data_xf = {cols_next[0], cols_next[1], cols_next[2], cols_next[3]};
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    data_d  = data_q;
    inv_d   = inv_q;
    valid_d = valid_q;
    rdy     = 1'b0;
    case (state_q)
      IDLE: rdy = 1'b1;
      BUSY: begin
        data_d = data_xf;
        step_d = step_q + 2'd1;
        if (step_q == LAST_STEP) begin
          step_d  = 2'd0;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        rdy = ready_out;
        if (ready_out) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy = rdy & reset;
    if (rdy && valid_in) begin
      data_d  = data_in;
      inv_d   = inv_in;
      step_d  = 2'd0;
      valid_d = 1'b0;
      state_d = BUSY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      // NOTE: the wide state register is reset too, so data_out reads zero
      // after reset and an aborted block never leaks out.
      data_q  <= '0;
      inv_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      data_q  <= data_d;
      inv_q   <= inv_d;
      valid_q <= valid_d;
    end
  end

  assign ready_in  = rdy;
  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Directed self-checking bench; instances 0/1/2 use COLS_PER_CYCLE = 1/2/4.
module tb_aes_mix_columns_iter;

  localparam logic [127:0] V_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V_FWD = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] B_A   = {4{32'hd4d4d4d5}};
  localparam logic [127:0] R_A   = {4{32'hd5d5d7d6}};
  localparam logic [127:0] B_B   = {4{32'h2d26314c}};
  localparam logic [127:0] R_B   = {4{32'h4d7ebdf8}};

  logic         clk = 1'b0;
  logic         reset     [3];
  logic         valid_in  [3];
  logic         ready_in  [3];
  logic         inv_in    [3];
  logic [127:0] data_in   [3];
  logic         valid_out [3];
  logic         ready_out [3];
  logic [127:0] data_out  [3];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    aes_mix_columns_iter #(
      .DATA_W         (128),
      .COLS_PER_CYCLE ((k == 0) ? 1 : (k == 1) ? 2 : 4)
    ) dut (
      .clk       (clk),
      .reset     (reset[k]),
      .valid_in  (valid_in[k]),
      .ready_in  (ready_in[k]),
      .inv_in    (inv_in[k]),
      .data_in   (data_in[k]),
      .valid_out (valid_out[k]),
      .ready_out (ready_out[k]),
      .data_out  (data_out[k])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Accept one block, wait for the result, check latency/data, then let it drain.
  task automatic run_block(input int k, input logic [127:0] din, input logic inv,
                           input logic [127:0] exp, input bit toggle_inv, input string tag);
    int lat;
    @(negedge clk);
    check({tag, "_ready_in"}, 128'(ready_in[k]), 128'(1));
    valid_in[k] = 1'b1;
    data_in[k]  = din;
    inv_in[k]   = inv;
    @(negedge clk);
    valid_in[k] = 1'b0;
    data_in[k]  = '0;
    lat = 0;
    while (!valid_out[k] && lat < 20) begin
      if (toggle_inv) inv_in[k] = ~inv_in[k];
      @(negedge clk);
      lat++;
    end
    inv_in[k] = 1'b0;
    check({tag, "_latency"}, 128'(lat), 128'(4 >> k));
    check({tag, "_data"}, data_out[k], exp);
    @(negedge clk);
    check({tag, "_valid_drop"}, 128'(valid_out[k]), 128'(0));
  endtask

  initial begin
    int lat;
    for (int k = 0; k < 3; k++) begin
      reset[k] = 1'b0; valid_in[k] = 1'b0; inv_in[k] = 1'b0;
      data_in[k] = '0; ready_out[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid_%0d", k), 128'(valid_out[k]), 128'(0));
      check($sformatf("rst_data_%0d", k), data_out[k], 128'(0));
      check($sformatf("rst_ready_%0d", k), 128'(ready_in[k]), 128'(0));
      reset[k] = 1'b1;
    end
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("rel_ready_%0d", k), 128'(ready_in[k]), 128'(1));

    // Forward and inverse on every width.
    for (int k = 0; k < 3; k++) begin
      run_block(k, V_IN, 1'b0, V_FWD, 1'b0, $sformatf("fwd_c%0d", 1 << k));
      run_block(k, V_FWD, 1'b1, V_IN, 1'b0, $sformatf("inv_c%0d", 1 << k));
    end

    // Backpressure on C=1: result held, ready_in low, valid_in ignored.
    ready_out[0] = 1'b0;
    @(negedge clk);
    valid_in[0] = 1'b1; data_in[0] = V_IN; inv_in[0] = 1'b0;
    @(negedge clk);
    valid_in[0] = 1'b0;
    lat = 0;
    while (!valid_out[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 128'(lat), 128'(4));
    for (int i = 0; i < 5; i++) begin
      valid_in[0] = 1'b1; data_in[0] = B_A; inv_in[0] = 1'b1;
      @(negedge clk);
      check($sformatf("bp_valid_%0d", i), 128'(valid_out[0]), 128'(1));
      check($sformatf("bp_data_%0d", i), data_out[0], V_FWD);
      check($sformatf("bp_ready_%0d", i), 128'(ready_in[0]), 128'(0));
    end
    valid_in[0] = 1'b0; inv_in[0] = 1'b0;
    ready_out[0] = 1'b1;
    #1;
    check("bp_ready_follows", 128'(ready_in[0]), 128'(1));
    @(negedge clk);
    check("bp_valid_drop", 128'(valid_out[0]), 128'(0));
    check("bp_idle_ready", 128'(ready_in[0]), 128'(1));

    // Back-to-back on C=4: a new block every two cycles.
    @(negedge clk);
    valid_in[2] = 1'b1; data_in[2] = B_A; inv_in[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("b2b_busy_%0d", i), 128'(valid_out[2]), 128'(0));
      data_in[2] = (i % 2 == 0) ? B_B : B_A;
      @(negedge clk);
      check($sformatf("b2b_valid_%0d", i), 128'(valid_out[2]), 128'(1));
      check($sformatf("b2b_data_%0d", i), data_out[2], (i % 2 == 0) ? R_A : R_B);
      check($sformatf("b2b_ready_%0d", i), 128'(ready_in[2]), 128'(1));
    end
    valid_in[2] = 1'b0;
    @(negedge clk);
    check("b2b_drain", 128'(valid_out[2]), 128'(0));

    // Mode latched at acceptance; inv_in toggling during BUSY is ignored.
    run_block(0, V_IN, 1'b0, V_FWD, 1'b1, "mode_latch");

    // Reset at step 2 of a C=1 block aborts it.
    @(negedge clk);
    valid_in[0] = 1'b1; data_in[0] = V_IN; inv_in[0] = 1'b0;
    @(negedge clk);
    valid_in[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset[0] = 1'b0;
    @(negedge clk);
    check("abort_valid", 128'(valid_out[0]), 128'(0));
    check("abort_data", data_out[0], 128'(0));
    check("abort_ready", 128'(ready_in[0]), 128'(0));
    reset[0] = 1'b1;
    #1;
    check("abort_rel_ready", 128'(ready_in[0]), 128'(1));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("abort_quiet_%0d", i), 128'(valid_out[0]), 128'(0));
    end
    run_block(0, B_B, 1'b0, R_B, 1'b0, "after_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
